// File: rtl/sata_fis_pkg.sv
// sata_fis_pkg: shared constants for the SATA command FIS engine.
//   - FIS type codes for Register H2D (host->device) and Register D2H
//   - ATA DMA EXT command opcodes
//   - bit positions inside the 8-bit AXI-Stream tuser {drop,err,keep[3:0],sop,eop}
//   - FSM state encoding
//   - sector_count(): byte length to 512-byte sector count
package sata_fis_pkg;

  localparam logic [7:0] FIS_TYPE_REG_H2D      = 8'h27;
  localparam logic [7:0] FIS_TYPE_REG_D2H      = 8'h34;
  localparam logic [7:0] ATA_CMD_READ_DMA_EXT  = 8'h25;
  localparam logic [7:0] ATA_CMD_WRITE_DMA_EXT = 8'h35;
  localparam logic [7:0] H2D_FLAG_CMD          = 8'h80;  // C bit: FIS carries a command
  localparam logic [7:0] DEV_LBA_MODE          = 8'h40;  // device register, LBA addressing

  localparam int TU_EOP     = 0;
  localparam int TU_SOP     = 1;
  localparam int TU_KEEP_LO = 2;
  localparam int TU_KEEP_HI = 5;
  localparam int TU_ERR     = 6;
  localparam int TU_DROP    = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_D2H = 2'd2
  } state_t;

  // Rounds the byte length up to whole sectors. A length of zero encodes
  // the maximum transfer of 2^23 bytes, i.e. 16384 sectors.
  function automatic logic [15:0] sector_count(input logic [22:0] len);
    logic [15:0] cnt;
    cnt = {2'b00, len[22:9]} + {15'd0, |len[8:0]};
    if (len == 23'd0) cnt = 16'd16384;
    return cnt;
  endfunction

endpackage

// File: rtl/sata_cmd_fis.sv
// sata_cmd_fis: issues one ATA READ/WRITE DMA EXT command as a Register H2D
// FIS and waits for the device's Register D2H FIS (or a timeout).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_dat[70:0]         {len[22:0] bytes, addr[47:0] byte address}
//   cmd_wr                0 = write, 1 = read
//   cmd_req / cmd_ack     command request, one-cycle acknowledge in IDLE
//   m_axis_fis_*          outgoing H2D FIS, 5 DWs, tuser {drop,err,keep,sop,eop}
//   s_axis_fis_*          incoming FIS stream, always ready after reset
//   busy                  command in flight (SEND or WAIT_D2H)
//   cmd_done / cmd_err    one-cycle completion pulse; err when status ERR or BSY
//   cmd_timeout           one-cycle pulse when no D2H arrived in TIMEOUT cycles
//   ata_status/ata_error  status and error bytes of the last accepted D2H FIS
module sata_cmd_fis
  import sata_fis_pkg::*;
#(
  parameter int TIMEOUT = 150000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [70:0] cmd_dat,
  input  logic        cmd_wr,
  input  logic        cmd_req,
  output logic        cmd_ack,
  output logic [31:0] m_axis_fis_tdata,
  output logic [7:0]  m_axis_fis_tuser,
  output logic        m_axis_fis_tvalid,
  input  logic        m_axis_fis_tready,
  input  logic [31:0] s_axis_fis_tdata,
  input  logic [7:0]  s_axis_fis_tuser,
  input  logic        s_axis_fis_tvalid,
  output logic        s_axis_fis_tready,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic        cmd_timeout,
  output logic [7:0]  ata_status,
  output logic [7:0]  ata_error
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic [2:0]  word_cnt;
  logic        wr_r;
  logic [38:0] lba_hi;      // addr[47:9]; LBA upper 9 bits are always zero
  logic [15:0] count_r;
  logic [31:0] tmo_cnt;
  logic        s_ready_r;   // low in reset, high from the first clock after
  logic        in_frame;    // inside a D2H frame whose sop has been seen
  logic        frame_ok;    // that frame still qualifies
  logic [7:0]  cap_status;
  logic [7:0]  cap_error;

  logic [47:0] lba;
  logic [31:0] dw;
  logic        sending;
  logic        rx_beat, rx_sop, rx_eop, rx_clean, rx_ok, rx_done, tmo_hit;
  logic [7:0]  rx_status, rx_error;
  logic        unused_bits;

  assign lba     = {9'b0, lba_hi};
  assign sending = (state == ST_SEND);
  assign busy    = (state != ST_IDLE);

  // Gated by s_ready_r so that a request held during reset is not acked.
  assign cmd_ack = (state == ST_IDLE) && cmd_req && s_ready_r;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    dw = 32'h0;
    case (word_cnt)
      3'd0: dw = {8'h00, wr_r ? ATA_CMD_READ_DMA_EXT : ATA_CMD_WRITE_DMA_EXT,
                  H2D_FLAG_CMD, FIS_TYPE_REG_H2D};
      3'd1: dw = {DEV_LBA_MODE, lba[23:0]};
      3'd2: dw = {8'h00, lba[47:24]};
      3'd3: dw = {16'h0000, count_r};
      default: dw = 32'h0;
    endcase
  end

  assign m_axis_fis_tvalid = sending;
  assign m_axis_fis_tdata  = sending ? dw : 32'h0;
  assign m_axis_fis_tuser  = sending ? {1'b0, 1'b0, 4'b1111, word_cnt == 3'd0, word_cnt == 3'd4}
                                     : 8'h00;
  assign s_axis_fis_tready = s_ready_r;

  // Incoming frame qualification: the sop word decides the FIS type, and a
  // drop/err flag on any word of the frame disqualifies the whole frame.
  assign rx_beat   = (state == ST_WAIT_D2H) && s_axis_fis_tvalid && s_ready_r;
  assign rx_sop    = s_axis_fis_tuser[TU_SOP];
  assign rx_eop    = s_axis_fis_tuser[TU_EOP];
  assign rx_clean  = !s_axis_fis_tuser[TU_DROP] && !s_axis_fis_tuser[TU_ERR];
  assign rx_ok     = rx_sop ? (s_axis_fis_tdata[7:0] == FIS_TYPE_REG_D2H) && rx_clean
                            : in_frame && frame_ok && rx_clean;
  assign rx_done   = rx_beat && rx_eop && rx_ok;
  // A single-word frame completes with the status bytes of that very word.
  assign rx_status = rx_sop ? s_axis_fis_tdata[23:16] : cap_status;
  assign rx_error  = rx_sop ? s_axis_fis_tdata[31:24] : cap_error;
  assign tmo_hit   = (state == ST_WAIT_D2H) && (tmo_cnt == TIMEOUT_LAST);

  assign unused_bits = &{1'b0, cmd_dat[8:0], s_axis_fis_tdata[15:8],
                         s_axis_fis_tuser[TU_KEEP_HI:TU_KEEP_LO]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      word_cnt    <= 3'd0;
      wr_r        <= 1'b0;
      lba_hi      <= '0;
      count_r     <= 16'd0;
      tmo_cnt     <= 32'd0;
      s_ready_r   <= 1'b0;
      in_frame    <= 1'b0;
      frame_ok    <= 1'b0;
      cap_status  <= 8'h00;
      cap_error   <= 8'h00;
      ata_status  <= 8'h00;
      ata_error   <= 8'h00;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_timeout <= 1'b0;
    end else begin
      s_ready_r   <= 1'b1;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_ack) begin
            wr_r     <= cmd_wr;
            lba_hi   <= cmd_dat[47:9];
            count_r  <= sector_count(cmd_dat[70:48]);
            word_cnt <= 3'd0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_axis_fis_tready) begin
            if (word_cnt == 3'd4) begin
              state    <= ST_WAIT_D2H;
              tmo_cnt  <= 32'd0;
              in_frame <= 1'b0;
              frame_ok <= 1'b0;
            end else begin
              word_cnt <= word_cnt + 3'd1;
            end
          end
        end
        ST_WAIT_D2H: begin
          if (rx_beat) begin
            if (rx_sop) begin
              cap_status <= s_axis_fis_tdata[23:16];
              cap_error  <= s_axis_fis_tdata[31:24];
            end
            in_frame <= !rx_eop && (rx_sop || in_frame);
            frame_ok <= rx_ok;
          end
          // A qualifying eop takes priority over a simultaneous expiry.
          if (rx_done) begin
            ata_status <= rx_status;
            ata_error  <= rx_error;
            cmd_done   <= 1'b1;
            cmd_err    <= rx_status[0] || rx_status[7];
            state      <= ST_IDLE;
          end else if (tmo_hit) begin
            cmd_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sata_cmd_fis.sv
// tb_sata_cmd_fis: self-checking bench for sata_cmd_fis (TIMEOUT = 16).
// Expected H2D words come from a byte/sector arithmetic model; D2H
// completion expectations come from the status byte rules.
module tb_sata_cmd_fis;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [70:0] cmd_dat = '0;
  logic        cmd_wr = 1'b0;
  logic        cmd_req = 1'b0;
  logic        cmd_ack;
  logic [31:0] m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [7:0]  s_tuser = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        busy, cmd_done, cmd_err, cmd_timeout;
  logic [7:0]  ata_status, ata_error;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_data [5];
  logic [7:0]  cap_user [5];
  int          got_words;
  bit          tvalid_dropped;

  sata_cmd_fis #(.TIMEOUT(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_dat           (cmd_dat),
    .cmd_wr            (cmd_wr),
    .cmd_req           (cmd_req),
    .cmd_ack           (cmd_ack),
    .m_axis_fis_tdata  (m_tdata),
    .m_axis_fis_tuser  (m_tuser),
    .m_axis_fis_tvalid (m_tvalid),
    .m_axis_fis_tready (m_tready),
    .s_axis_fis_tdata  (s_tdata),
    .s_axis_fis_tuser  (s_tuser),
    .s_axis_fis_tvalid (s_tvalid),
    .s_axis_fis_tready (s_tready),
    .busy              (busy),
    .cmd_done          (cmd_done),
    .cmd_err           (cmd_err),
    .cmd_timeout       (cmd_timeout),
    .ata_status        (ata_status),
    .ata_error         (ata_error)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_dw(input int idx, input logic [47:0] addr,
                                           input logic [22:0] len, input logic wr);
    longint unsigned lba;
    int unsigned     sectors;
    lba     = 64'(addr) / 512;
    sectors = (len == 23'd0) ? 16384 : (int'(len) + 511) / 512;
    case (idx)
      0: return wr ? 32'h0025_8027 : 32'h0035_8027;
      1: return 32'h4000_0000 | 32'(lba % 64'd16777216);
      2: return 32'(lba / 64'd16777216);
      3: return 32'(sectors);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] model_user(input int idx);
    return 8'h3C | ((idx == 0) ? 8'h02 : 8'h00) | ((idx == 4) ? 8'h01 : 8'h00);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_cmd(input logic [47:0] addr, input logic [22:0] len, input logic wr);
    @(negedge clk);
    cmd_dat = {len, addr}; cmd_wr = wr; cmd_req = 1'b1; m_tready = 1'b0;
    #1;
    checks++;
    if (cmd_ack !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL cmd_ack_idle: got ack=%b busy=%b expected ack=1 busy=0", cmd_ack, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ack !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL cmd_ack_send: got ack=%b busy=%b expected ack=0 busy=1", cmd_ack, busy);
    end
    cmd_req = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle every cycle, 2: random. Returns at the
  // negedge before the clock edge that accepts DW4.
  task automatic collect_fis(input int mode);
    int n;
    n = 0; tvalid_dropped = 1'b0;
    for (int cyc = 0; cyc < 80 && n < 5; cyc++) begin
      @(negedge clk);
      case (mode)
        0: m_tready = 1'b1;
        1: m_tready = cyc[0];
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (m_tvalid !== 1'b1) tvalid_dropped = 1'b1;
      if (m_tvalid && m_tready) begin
        cap_data[n] = m_tdata; cap_user[n] = m_tuser; n++;
      end
    end
    got_words = n;
    checks++;
    if (got_words != 5) begin
      errors++; $display("FAIL fis_word_count: got %0d expected 5", got_words);
    end
    checks++;
    if (tvalid_dropped) begin
      errors++; $display("FAIL fis_tvalid_hold: got tvalid low mid-frame expected held high");
    end
  endtask

  task automatic d2h_word(input logic [31:0] data, input logic sop, input logic eop,
                          input logic drop, input logic err);
    @(negedge clk);
    s_tdata = data; s_tuser = {drop, err, 4'hF, sop, eop}; s_tvalid = 1'b1;
  endtask

  task automatic d2h_idle();
    @(negedge clk);
    s_tvalid = 1'b0; s_tuser = 8'h00; s_tdata = 32'h0;
    #1;
  endtask

  // bad_idx >= 0 sets err on that word.
  task automatic d2h_frame(input logic [7:0] ftype, input logic [7:0] status,
                           input logic [7:0] error, input int nwords, input int bad_idx);
    for (int i = 0; i < nwords; i++)
      d2h_word((i == 0) ? {error, status, 8'h40, ftype} : $urandom,
               i == 0, i == nwords - 1, 1'b0, i == bad_idx);
    d2h_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cmd_req = 1'b1;   // must not be acked while in reset
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({m_tdata, m_tuser, m_tvalid, cmd_ack, busy, cmd_done, cmd_err, cmd_timeout,
         ata_status, ata_error, s_tready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tdata=%h tuser=%h tvalid=%b ack=%b busy=%b ready=%b expected all 0",
               m_tdata, m_tuser, m_tvalid, cmd_ack, busy, s_tready);
    end
    cmd_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", s_tready, busy);
    end
  endtask

  task automatic test_write_directed();
    logic [31:0] exp_dw [5];
    exp_dw = '{32'h0035_8027, 32'h4000_0009, 32'h0, 32'h0000_0004, 32'h0};
    send_cmd(48'h0000_0000_1200, 23'd2048, 1'b0);
    collect_fis(0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cap_user[i], cap_data[i]} !== {model_user(i), exp_dw[i]}) begin
        errors++; $display("FAIL write_dw%0d: got user=%h data=%h expected user=%h data=%h",
                           i, cap_user[i], cap_data[i], model_user(i), exp_dw[i]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tuser !== 8'h00 || busy !== 1'b1) begin
      errors++; $display("FAIL write_after_eop: got tvalid=%b tuser=%h busy=%b expected 0 00 1", m_tvalid, m_tuser, busy);
    end
    d2h_frame(8'h34, 8'h50, 8'h00, 5, -1);
    checks++;
    if ({cmd_done, cmd_err, cmd_timeout, busy, ata_status, ata_error} !== {4'b1000, 8'h50, 8'h00}) begin
      errors++; $display("FAIL write_done: got done=%b err=%b tmo=%b busy=%b status=%h error=%h expected 1 0 0 0 50 00",
                         cmd_done, cmd_err, cmd_timeout, busy, ata_status, ata_error);
    end
    @(negedge clk); #1;
    checks++;
    if (cmd_done !== 1'b0) begin
      errors++; $display("FAIL write_done_pulse: got done=%b expected 0", cmd_done);
    end
  endtask

  task automatic test_read_len();
    send_cmd(48'h0000_0000_0000, 23'd0, 1'b1);
    collect_fis(0);
    checks++;
    if (cap_data[0] !== 32'h0025_8027 || cap_data[3] !== 32'h0000_4000) begin
      errors++; $display("FAIL read_len0: got dw0=%h dw3=%h expected 00258027 00004000", cap_data[0], cap_data[3]);
    end
    d2h_frame(8'h34, 8'h40, 8'h00, 5, -1);
    send_cmd(48'h0000_0000_01FF, 23'd513, 1'b1);
    collect_fis(0);
    checks++;
    if (cap_data[1] !== 32'h4000_0000 || cap_data[3] !== 32'h0000_0002) begin
      errors++; $display("FAIL read_len513: got dw1=%h dw3=%h expected 40000000 00000002", cap_data[1], cap_data[3]);
    end
    d2h_frame(8'h34, 8'h40, 8'h00, 5, -1);
  endtask

  task automatic test_backpressure();
    logic [47:0] addr;
    logic [22:0] len;
    addr = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    len  = 23'($urandom);
    send_cmd(addr, len, 1'b0);
    collect_fis(1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cap_user[i], cap_data[i]} !== {model_user(i), model_dw(i, addr, len, 1'b0)}) begin
        errors++; $display("FAIL toggle_dw%0d: got user=%h data=%h expected user=%h data=%h",
                           i, cap_user[i], cap_data[i], model_user(i), model_dw(i, addr, len, 1'b0));
      end
    end
    d2h_frame(8'h34, 8'h50, 8'h00, 5, -1);
  endtask

  task automatic test_d2h_filter();
    send_cmd(48'h0000_0010_0000, 23'd4096, 1'b1);
    collect_fis(0);
    d2h_frame(8'h39, 8'h50, 8'h00, 2, -1);
    checks++;
    if (cmd_done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL filter_type39: got done=%b busy=%b expected 0 1", cmd_done, busy);
    end
    d2h_frame(8'h34, 8'h50, 8'h00, 3, 1);
    checks++;
    if (cmd_done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL filter_err: got done=%b busy=%b expected 0 1", cmd_done, busy);
    end
    d2h_frame(8'h34, 8'h51, 8'h04, 5, -1);
    checks++;
    if ({cmd_done, cmd_err, cmd_timeout, ata_status, ata_error} !== {3'b110, 8'h51, 8'h04}) begin
      errors++; $display("FAIL filter_good: got done=%b err=%b tmo=%b status=%h error=%h expected 1 1 0 51 04",
                         cmd_done, cmd_err, cmd_timeout, ata_status, ata_error);
    end
  endtask

  task automatic test_timeout();
    int first_hi, n_hi;
    bit done_seen;
    first_hi = -1; n_hi = 0; done_seen = 1'b0;
    send_cmd(48'h0000_0000_0400, 23'd512, 1'b0);
    collect_fis(0);
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;           // k = 0 is the edge that accepts DW4
      if (cmd_timeout === 1'b1) begin
        if (first_hi < 0) first_hi = k;
        n_hi++;
      end
      if (cmd_done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (first_hi != 16 || n_hi != 1 || done_seen || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got first=%0d width=%0d done=%b busy=%b expected 16 1 0 0",
                         first_hi, n_hi, done_seen, busy);
    end
  endtask

  task automatic test_coincident();
    send_cmd(48'h0000_0000_0800, 23'd1024, 1'b1);
    collect_fis(0);
    repeat (16) @(posedge clk);      // now just past the 15th edge after DW4
    d2h_word({8'h00, 8'h50, 8'h40, 8'h34}, 1'b1, 1'b1, 1'b0, 1'b0);
    d2h_idle();
    checks++;
    if (cmd_done !== 1'b1 || cmd_timeout !== 1'b0 || cmd_err !== 1'b0) begin
      errors++; $display("FAIL coincident_edge: got done=%b tmo=%b err=%b expected 1 0 0", cmd_done, cmd_timeout, cmd_err);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_timeout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL coincident_after: got tmo=%b busy=%b expected 0 0", cmd_timeout, busy);
    end
  endtask

  task automatic test_random();
    logic [47:0] addr;
    logic [22:0] len;
    logic        wr;
    logic [7:0]  status, error;
    for (int it = 0; it < 8; it++) begin
      addr = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      len  = ($urandom_range(0, 3) == 0) ? 23'($urandom_range(0, 1024)) : 23'($urandom);
      wr   = 1'($urandom_range(0, 1));
      status = 8'($urandom); error = 8'($urandom);
      send_cmd(addr, len, wr);
      collect_fis(2);
      for (int i = 0; i < 5; i++) begin
        checks++;
        if ({cap_user[i], cap_data[i]} !== {model_user(i), model_dw(i, addr, len, wr)}) begin
          errors++; $display("FAIL rand%0d_dw%0d: got user=%h data=%h expected user=%h data=%h",
                             it, i, cap_user[i], cap_data[i], model_user(i), model_dw(i, addr, len, wr));
        end
      end
      d2h_frame(8'h34, status, error, 5, -1);
      checks++;
      if ({cmd_done, cmd_err, ata_status, ata_error} !== {1'b1, status[0] | status[7], status, error}) begin
        errors++; $display("FAIL rand%0d_done: got done=%b err=%b status=%h error=%h expected 1 %b %h %h",
                           it, cmd_done, cmd_err, ata_status, ata_error, status[0] | status[7], status, error);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [47:0] addr;
    addr = 48'h0123_4567_8A00;
    send_cmd(addr, 23'd8192, 1'b0);
    @(negedge clk); m_tready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (m_tdata !== model_dw(2, addr, 23'd8192, 1'b0)) begin
      errors++; $display("FAIL midsend_dw2: got %h expected %h", m_tdata, model_dw(2, addr, 23'd8192, 1'b0));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_tdata, m_tuser, m_tvalid, cmd_ack, busy, cmd_done, cmd_err, cmd_timeout,
         ata_status, ata_error, s_tready} !== '0) begin
      errors++;
      $display("FAIL midsend_reset: got tdata=%h tuser=%h tvalid=%b busy=%b status=%h ready=%b expected all 0",
               m_tdata, m_tuser, m_tvalid, busy, ata_status, s_tready);
    end
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midsend_release: got tvalid=%b busy=%b expected 0 0", m_tvalid, busy);
    end
    send_cmd(48'h0000_0000_0200, 23'd512, 1'b1);
    collect_fis(0);
    checks++;
    if (cap_data[0] !== 32'h0025_8027 || cap_data[1] !== 32'h4000_0001) begin
      errors++; $display("FAIL midsend_newcmd: got dw0=%h dw1=%h expected 00258027 40000001", cap_data[0], cap_data[1]);
    end
    d2h_frame(8'h34, 8'h50, 8'h00, 5, -1);
  endtask

  initial begin
    test_reset();
    test_write_directed();
    test_read_len();
    test_backpressure();
    test_d2h_filter();
    test_timeout();
    test_coincident();
    test_random();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sata_cmd_fis.md
SATA_CMD_FIS -- requirements
Module: sata_cmd_fis

Interface
REQ-001 SHALL have parameter TIMEOUT, default 150000000, meaning D2H wait limit in clk cycles.
REQ-002 SHALL have ports clk in 1 (sole clock) and rst_n in 1 (reset, asynchronous, active-low), listed first.
REQ-003 SHALL have cmd_dat in 71 {len[22:0] bytes, addr[47:0] byte address}, cmd_wr in 1 (0 write, 1 read), cmd_req in 1, cmd_ack out 1.
REQ-004 SHALL have m_axis_fis_tdata out 32, m_axis_fis_tuser out 8 {drop,err,keep[3:0],sop,eop}, m_axis_fis_tvalid out 1, m_axis_fis_tready in 1.
REQ-005 SHALL have s_axis_fis_tdata in 32, s_axis_fis_tuser in 8 (same layout), s_axis_fis_tvalid in 1, s_axis_fis_tready out 1.
REQ-006 SHALL have busy out 1, cmd_done out 1, cmd_err out 1, cmd_timeout out 1, ata_status out 8, ata_error out 8.

Function
REQ-007 SHALL use FSM IDLE -> SEND -> WAIT_D2H -> IDLE.
REQ-008 In IDLE with cmd_req=1, SHALL pulse cmd_ack for exactly one cycle, latch cmd_dat/cmd_wr, and enter SEND next cycle.
REQ-009 cmd_ack SHALL be 0 in every state other than IDLE.
REQ-010 SEND SHALL emit 5 DWs of a Register H2D FIS, advancing only on tvalid&&tready, with tvalid held high until DW4 is accepted.
REQ-011 DW0 SHALL be {features 8'h00, command, 8'h80, 8'h27}; command SHALL be 8'h35 when cmd_wr=0 and 8'h25 when cmd_wr=1.
REQ-012 DW1 SHALL be {8'h40, LBA[23:0]}, DW2 {8'h00, LBA[47:24]}, DW3 {16'h0000, count[15:0]}, DW4 32'h0.
REQ-013 LBA SHALL be {9'b0, addr[47:9]}; addr[8:0] SHALL be ignored.
REQ-014 count SHALL be len[22:9] + (|len[8:0]).
REQ-015 When len==0, count SHALL be 16'd16384 (2^23 bytes).
REQ-016 m_axis tuser SHALL be sop=1 on DW0 only, eop=1 on DW4 only, keep=4'b1111, drop=err=0.
REQ-017 After DW4 is accepted, the FSM SHALL enter WAIT_D2H and clear the timeout counter.
REQ-018 s_axis_fis_tready SHALL be 1 in all states; words accepted outside WAIT_D2H SHALL be discarded.
REQ-019 In WAIT_D2H, a frame SHALL qualify only if its sop word has tdata[7:0]==8'h34 and no word in it has tuser drop or err set.
REQ-020 On a qualifying frame's sop word, status=tdata[23:16] and error=tdata[31:24] SHALL be captured.
REQ-021 At a qualifying frame's eop, ata_status/ata_error SHALL update, cmd_done SHALL pulse 1 cycle, and the FSM SHALL return to IDLE.
REQ-022 cmd_err SHALL pulse together with cmd_done when status bit0 (ERR) or bit7 (BSY) is set.
REQ-023 Non-qualifying frames SHALL be discarded and the FSM SHALL stay in WAIT_D2H.
REQ-024 A single-word frame (sop&&eop) SHALL complete within that cycle.
REQ-025 If the timeout counter reaches TIMEOUT-1 in WAIT_D2H, cmd_timeout SHALL pulse 1 cycle with cmd_done=0 and the FSM SHALL return to IDLE.
REQ-026 If a qualifying eop and timeout expiry occur in the same cycle, eop SHALL win and cmd_timeout SHALL stay 0.
REQ-027 busy SHALL be 1 in SEND and WAIT_D2H, else 0.
REQ-028 cmd_req SHALL be ignored while busy=1.

Reset
REQ-029 On rst_n low, state SHALL be IDLE and all outputs SHALL be 0 (ata_status, ata_error, m_axis tdata/tuser/tvalid, cmd_ack, pulses, busy).
REQ-030 s_axis_fis_tready SHALL be 0 during reset and 1 from the first cycle after release.
REQ-031 Reset asserted mid-SEND or mid-WAIT SHALL abort the FIS with no eop emitted, and no pending state SHALL survive reset.

Structure
REQ-032 Package sata_fis_pkg SHALL hold FIS type constants (8'h27, 8'h34), ATA commands (8'h25, 8'h35), the 8-bit tuser bit indices, and the state enum.
REQ-033 The block SHALL be a single module with no sub-module; DW selection SHALL use a 3-bit word counter.

Verification
REQ-034 Write, addr=48'h0000_0000_1200, len=23'd2048 -> DW0=32'h00358027, DW1=32'h40000009, DW2=0, DW3=32'h00000004; D2H status 8'h50 -> cmd_done=1, cmd_err=0.
REQ-035 Read, len=23'd0 -> DW0=32'h00258027, DW3=32'h00004000; len=23'd513 -> count=2.
REQ-036 m_axis_fis_tready toggled 1/0 every cycle -> 5 DWs in order, sop/eop correct, tvalid never drops mid-frame.
REQ-037 D2H frames: type 8'h39 first -> ignored; then 8'h34 with err=1 -> ignored; then valid 8'h34 with status 8'h51 -> cmd_done=1, cmd_err=1, ata_status=8'h51.
REQ-038 TIMEOUT=16, no D2H -> cmd_timeout pulses 16 cycles after DW4 accepted; eop coincident with expiry -> cmd_done only.
REQ-039 rst_n low at SEND DW2 -> all outputs 0 asynchronously; after release, a new cmd_req is acked in 1 cycle.
